// File: rtl/button_conditioner.sv
// Per-channel button conditioning: polarity normalisation, 2-flop synchroniser,
// counting debouncer, press/release pulses and a sticky request latch.
module button_conditioner #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] btn_raw,
  input  logic [N_BUTTONS-1:0] clear,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] req_latched
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  // After normalisation 1 = pushed, so the released/reset value is 0 everywhere.
  logic [N_BUTTONS-1:0] pushed;
  assign pushed = ACTIVE_LOW ? ~btn_raw : btn_raw;

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
      logic          sync1_q, sync2_q;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic          req_q, req_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          accept;

      always_comb begin
        cnt_d  = '0;
        accept = 1'b0;
        if (sync2_q != level_q) begin
          if (cnt_q == CNT_LAST) begin
            accept = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        level_d   = level_q ^ accept;
        press_d   = accept & ~level_q;
        release_d = accept & level_q;
        // An accepted press wins over a coincident clear.
        req_d     = press_d ? 1'b1 : (clear[gi] ? 1'b0 : req_q);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q   <= 1'b0;
          sync2_q   <= 1'b0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          req_q     <= 1'b0;
          cnt_q     <= '0;
        end else begin
          sync1_q   <= pushed[gi];
          sync2_q   <= sync1_q;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
          req_q     <= req_d;
          cnt_q     <= cnt_d;
        end
      end

      assign btn_level[gi]   = level_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = release_q;
      assign req_latched[gi] = req_q;
    end
  endgenerate

endmodule
